l1_cache_responder: RTL and testbench

- Direct-mapped, write-back L1 cache that serves one CPU port (instruction or data). It is the responder side of the CPU's 16-bit read/write/wmask/resp memory handshake.
- It sits between the pipeline datapath and the physical-memory arbiter. Misses are filled, and dirty evictions are written back, as 128-bit line transfers.
- The same block is instantiated twice: once as the icache and once as the dcache.

---
 rtl/l1_cache_responder.sv | 159 +++++++++++++++
 tb/tb_l1_cache_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_cache_responder.sv
`default_nettype none
// ============================================================================
// Module   : l1_cache_responder
// Brief    : Direct-mapped write-back L1 cache with a zero-cycle hit path.
//            Misses are handled with 128-bit line writebacks and fills.
// Revision : 1.0 - initial release
// ============================================================================
module l1_cache_responder #(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_wmask,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    output logic         mem_resp,
    output logic [15:0]  mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata
);

    localparam int c_SETS   = 1 << S_INDEX;
    localparam int c_LINE_W = 8 << S_OFFSET;
    localparam int c_TAG_W  = 16 - S_INDEX - S_OFFSET;
    localparam int c_WORD_W = S_OFFSET - 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_SETS-1:0]     r_valid;
    logic [c_SETS-1:0]     r_dirty;
    logic [c_TAG_W-1:0]    r_tag  [c_SETS];
    logic [c_LINE_W-1:0]   r_data [c_SETS];

    logic                  r_pmem_read;
    logic                  r_pmem_write;
    logic [15:0]           r_pmem_address;
    logic [c_LINE_W-1:0]   r_pmem_wdata;

    logic [c_TAG_W-1:0]    w_tag;
    logic [S_INDEX-1:0]    w_index;
    logic [c_WORD_W-1:0]   w_word;
    logic [S_INDEX-1:0]    w_fill_index;
    logic [c_WORD_W+3:0]   w_bit_lo;
    logic [c_WORD_W+3:0]   w_bit_hi;
    logic [c_LINE_W-1:0]   w_line;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_resp;
    logic                  w_do_write;
    logic                  w_fill;
    logic                  w_unused_addr_bit;

    assign w_tag        = mem_address[15 -: c_TAG_W];
    assign w_index      = mem_address[S_OFFSET +: S_INDEX];
    assign w_word       = mem_address[1 +: c_WORD_W];
    assign w_fill_index = r_pmem_address[S_OFFSET +: S_INDEX];
    assign w_bit_lo     = {w_word, 4'b0000};
    assign w_bit_hi     = {w_word, 4'b1000};
    assign w_line       = r_data[w_index];
    assign w_unused_addr_bit = mem_address[0];

    assign w_req      = mem_read | mem_write;
    assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_resp     = (r_state == S_IDLE) && w_req && w_hit;
    assign w_do_write = w_resp && mem_write && (mem_wmask != 2'b00);
    assign w_fill     = (r_state == S_ALLOCATE) && pmem_resp;

    assign mem_resp     = w_resp;
    assign mem_rdata    = w_resp ? w_line[w_bit_lo +: 16] : 16'h0000;
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;

    // Line storage; the fill target comes from the latched line address so a
    // request that changes mid-miss cannot redirect the incoming line.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_fill) begin
                r_data[w_fill_index] <= pmem_rdata;
                r_tag[w_fill_index]  <= r_pmem_address[15 -: c_TAG_W];
            end else if (w_do_write) begin
                if (mem_wmask[0]) r_data[w_index][w_bit_lo +: 8] <= mem_wdata[7:0];
                if (mem_wmask[1]) r_data[w_index][w_bit_hi +: 8] <= mem_wdata[15:8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_valid        <= '0;
            r_dirty        <= '0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            if (w_do_write) r_dirty[w_index] <= 1'b1;
                        end else if (r_valid[w_index] && r_dirty[w_index]) begin
                            r_state        <= S_WRITEBACK;
                            r_pmem_write   <= 1'b1;
                            r_pmem_address <= {r_tag[w_index], w_index, {S_OFFSET{1'b0}}};
                            r_pmem_wdata   <= w_line;
                        end else begin
                            r_state        <= S_ALLOCATE;
                            r_pmem_read    <= 1'b1;
                            r_pmem_address <= {w_tag, w_index, {S_OFFSET{1'b0}}};
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (pmem_resp) begin
                        r_dirty[w_fill_index] <= 1'b0;
                        r_state        <= S_ALLOCATE;
                        r_pmem_write   <= 1'b0;
                        r_pmem_wdata   <= '0;
                        r_pmem_read    <= 1'b1;
                        r_pmem_address <= {w_tag, w_index, {S_OFFSET{1'b0}}};
                    end
                end
                S_ALLOCATE: begin
                    if (pmem_resp) begin
                        r_valid[w_fill_index] <= 1'b1;
                        r_dirty[w_fill_index] <= 1'b0;
                        r_state        <= S_IDLE;
                        r_pmem_read    <= 1'b0;
                        r_pmem_address <= '0;
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_pmem_read    <= 1'b0;
                    r_pmem_write   <= 1'b0;
                    r_pmem_address <= '0;
                    r_pmem_wdata   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l1_cache_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1_cache_responder
// Brief    : Directed vector bench for the L1 cache responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l1_cache_responder;

    localparam logic [127:0] c_LINE_A     = 128'h3333_2222_1111_00EE_00DD_00CC_00BB_00AA;
    localparam logic [127:0] c_LINE_A_MOD = 128'h3333_2222_BEEF_0034_00DD_ABCC_00BB_00AA;
    localparam logic [127:0] c_LINE_B     = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    localparam logic [127:0] c_LINE_C     = 128'hC7C7_C6C6_C5C5_C4C4_C3C3_C2C2_C1C1_C0C0;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_wmask;
    logic [15:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic         mem_resp;
    logic [15:0]  mem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [1:0]  m;
        logic [15:0] a;
        logic [15:0] d;
        logic        resp;
        logic        chk_rd;
        logic [15:0] rdata;
    } vec_t;

    vec_t tbl [13];

    l1_cache_responder dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wmask    (mem_wmask),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_resp     (mem_resp),
        .mem_rdata    (mem_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic [1:0] m,
                       input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        mem_read    = rd;
        mem_write   = wr;
        mem_wmask   = m;
        mem_address = a;
        mem_wdata   = d;
        #2;
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic pmem_ack(input logic [127:0] line);
        @(negedge clk);
        pmem_resp  = 1'b1;
        pmem_rdata = line;
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 2'b00, 16'h1236, 16'h0000, 1'b1, 1'b1, 16'h00DD};
        tbl[1]  = '{1'b1, 1'b0, 2'b00, 16'h123E, 16'h0000, 1'b1, 1'b1, 16'h3333};
        tbl[2]  = '{1'b1, 1'b0, 2'b00, 16'h1230, 16'h0000, 1'b1, 1'b1, 16'h00AA};
        tbl[3]  = '{1'b0, 1'b1, 2'b10, 16'h1234, 16'hABCD, 1'b1, 1'b0, 16'h0000};
        tbl[4]  = '{1'b1, 1'b0, 2'b00, 16'h1234, 16'h0000, 1'b1, 1'b1, 16'hABCC};
        tbl[5]  = '{1'b0, 1'b1, 2'b01, 16'h1238, 16'h1234, 1'b1, 1'b0, 16'h0000};
        tbl[6]  = '{1'b1, 1'b0, 2'b00, 16'h1238, 16'h0000, 1'b1, 1'b1, 16'h0034};
        tbl[7]  = '{1'b0, 1'b1, 2'b11, 16'h123A, 16'hBEEF, 1'b1, 1'b0, 16'h0000};
        tbl[8]  = '{1'b1, 1'b0, 2'b00, 16'h123A, 16'h0000, 1'b1, 1'b1, 16'hBEEF};
        tbl[9]  = '{1'b1, 1'b1, 2'b00, 16'h1230, 16'hFFFF, 1'b1, 1'b0, 16'h0000};
        tbl[10] = '{1'b1, 1'b0, 2'b00, 16'h1230, 16'h0000, 1'b1, 1'b1, 16'h00AA};
        tbl[11] = '{1'b0, 1'b0, 2'b00, 16'h1230, 16'h0000, 1'b0, 1'b1, 16'h0000};
        tbl[12] = '{1'b1, 1'b0, 2'b00, 16'h1235, 16'h0000, 1'b1, 1'b1, 16'hABCC};

        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_wmask = 2'b00;
        mem_address = '0; mem_wdata = '0; pmem_resp = 1'b0; pmem_rdata = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_mem_resp", mem_resp, 0);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_address", pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        reset = 1'b0;

        // Cold read of 0x1234
        req(1, 0, 2'b00, 16'h1234, 16'h0000);
        chk("cold_resp_idle", mem_resp, 0);
        chk("cold_no_pmem_in_idle", pmem_read, 0);
        tick();
        chk("cold_pmem_read", pmem_read, 1);
        chk("cold_pmem_write", pmem_write, 0);
        chk("cold_pmem_address", pmem_address, 16'h1230);
        chk("cold_resp_alloc", mem_resp, 0);
        tick();
        chk("cold_pmem_read_held", pmem_read, 1);
        chk("cold_pmem_address_held", pmem_address, 16'h1230);
        pmem_ack(c_LINE_A);
        chk("cold_resp", mem_resp, 1);
        chk("cold_rdata", mem_rdata, 16'h00CC);
        chk("cold_pmem_read_done", pmem_read, 0);

        // Hit-path vector table
        for (int i = 0; i < 13; i++) begin
            req(tbl[i].rd, tbl[i].wr, tbl[i].m, tbl[i].a, tbl[i].d);
            chk($sformatf("vec%0d_resp", i), mem_resp, tbl[i].resp);
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), mem_rdata, tbl[i].rdata);
            chk($sformatf("vec%0d_pmem_read", i), pmem_read, 0);
            chk($sformatf("vec%0d_pmem_write", i), pmem_write, 0);
        end

        // Dirty eviction: 0x5234 shares the index of the modified 0x1230 line
        req(1, 0, 2'b00, 16'h5234, 16'h0000);
        chk("evict_resp_miss", mem_resp, 0);
        tick();
        chk("evict_pmem_write", pmem_write, 1);
        chk("evict_pmem_read", pmem_read, 0);
        chk("evict_address", pmem_address, 16'h1230);
        chk("evict_wdata", pmem_wdata, c_LINE_A_MOD);
        tick();
        chk("evict_write_held", pmem_write, 1);
        chk("evict_wdata_held", pmem_wdata, c_LINE_A_MOD);
        pmem_ack('0);
        chk("evict_then_write", pmem_write, 0);
        chk("evict_then_read", pmem_read, 1);
        chk("evict_fill_address", pmem_address, 16'h5230);
        chk("evict_fill_resp", mem_resp, 0);
        pmem_ack(c_LINE_B);
        chk("evict_done_resp", mem_resp, 1);
        chk("evict_done_rdata", mem_rdata, 16'h2222);
        chk("evict_done_pmem_read", pmem_read, 0);
        chk("evict_done_address", pmem_address, 0);

        // wmask=00 write must leave the line clean
        req(1, 0, 2'b00, 16'h0012, 16'h0000);
        tick();
        chk("idx1_pmem_read", pmem_read, 1);
        chk("idx1_pmem_write", pmem_write, 0);
        chk("idx1_address", pmem_address, 16'h0010);
        pmem_ack(c_LINE_C);
        chk("idx1_resp", mem_resp, 1);
        chk("idx1_rdata", mem_rdata, 16'hC1C1);
        req(1, 1, 2'b00, 16'h0012, 16'hFFFF);
        chk("m00_resp", mem_resp, 1);
        req(1, 0, 2'b00, 16'h0012, 16'h0000);
        chk("m00_rdata_kept", mem_rdata, 16'hC1C1);
        req(1, 0, 2'b00, 16'h8012, 16'h0000);
        chk("m00_miss_resp", mem_resp, 0);
        tick();
        chk("m00_no_writeback", pmem_write, 0);
        chk("m00_direct_fill", pmem_read, 1);
        chk("m00_fill_address", pmem_address, 16'h8010);
        pmem_ack(c_LINE_A);
        chk("m00_fill_resp", mem_resp, 1);
        chk("m00_fill_rdata", mem_rdata, 16'h00BB);

        // Reset during ALLOCATE, then a stray pmem_resp
        req(1, 0, 2'b00, 16'h1234, 16'h0000);
        chk("rsta_miss_resp", mem_resp, 0);
        tick();
        chk("rsta_pmem_read", pmem_read, 1);
        chk("rsta_pmem_write", pmem_write, 0);
        chk("rsta_address", pmem_address, 16'h1230);
        @(negedge clk);
        reset = 1'b1;
        mem_read = 1'b0;
        @(negedge clk);
        #2;
        chk("rsta_after_pmem_read", pmem_read, 0);
        chk("rsta_after_resp", mem_resp, 0);
        chk("rsta_after_address", pmem_address, 0);
        reset = 1'b0;
        pmem_ack(c_LINE_A);
        chk("stray_pmem_read", pmem_read, 0);
        chk("stray_pmem_write", pmem_write, 0);
        chk("stray_resp", mem_resp, 0);
        req(1, 0, 2'b00, 16'h5234, 16'h0000);
        chk("reread_miss", mem_resp, 0);
        tick();
        chk("reread_pmem_read", pmem_read, 1);
        chk("reread_pmem_write", pmem_write, 0);
        chk("reread_address", pmem_address, 16'h5230);
        pmem_ack(c_LINE_B);
        chk("reread_resp", mem_resp, 1);
        chk("reread_rdata", mem_rdata, 16'h2222);

        @(negedge clk);
        mem_read = 1'b0;
        mem_write = 1'b0;
        #2;
        chk("final_idle_resp", mem_resp, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
